// File: rtl/mult_seq_initiator.sv
// mult_seq_initiator: request-side sequencer for the 4-bit shift-add multiplier.
// It accepts an operand pair, raises strt_cmpt_o until the controller reports END,
// captures the product into a one-entry buffer, then waits for the controller to
// return to IDLE before taking the next pair.
// Optional feature macro: MULT_SEQ_TIMEOUT_EN adds a per-phase watchdog that sets
// a sticky err_o. Without it, err_o is tied low and the sequencer waits indefinitely.
module mult_seq_initiator #(
  parameter int OP_W    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [OP_W-1:0]   op_a_i,
  input  logic [OP_W-1:0]   op_b_i,
  input  logic              op_valid_i,
  output logic              op_ready_o,
  output logic [OP_W-1:0]   mcand_o,
  output logic [OP_W-1:0]   mplier_o,
  output logic              strt_cmpt_o,
  input  logic [2:0]        state_i,
  input  logic [2*OP_W-1:0] product_i,
  output logic [2*OP_W-1:0] prod_o,
  output logic              prod_valid_o,
  input  logic              prod_ready_i,
  output logic [7:0]        done_cnt_o,
  output logic              err_o,
  input  logic              clr_err_i
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  // Multiplier controller state codes that the sequencer reacts to.
  localparam logic [2:0] CTL_IDLE = 3'd0;
  localparam logic [2:0] CTL_END  = 3'd5;

  state_t            state_q, state_d;
  logic [OP_W-1:0]   mcand_q, mcand_d;
  logic [OP_W-1:0]   mplier_q, mplier_d;
  logic              strt_q, strt_d;
  logic [2*OP_W-1:0] prod_q, prod_d;
  logic              prod_valid_q, prod_valid_d;
  logic [7:0]        done_cnt_q, done_cnt_d;

`ifdef MULT_SEQ_TIMEOUT_EN
  // The watchdog fires on the cycle that would bring the phase count to TIMEOUT.
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wd_q, wd_d;
  logic       err_q, err_d;
  logic       wd_fire;
`else
  logic unused_clr_err;
  assign unused_clr_err = clr_err_i;
`endif

  // A new pair is only taken while idle and with the product buffer empty,
  // so a capture can never overwrite an unconsumed product.
  assign op_ready_o = (state_q == S_IDLE) && !prod_valid_q;

  // Next-state, capture and buffer logic.
  always_comb begin
    state_d      = state_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    prod_d       = prod_q;
    prod_valid_d = prod_valid_q;
    done_cnt_d   = done_cnt_q;
`ifdef MULT_SEQ_TIMEOUT_EN
    wd_fire      = (wd_q == WD_LAST);
    err_d        = clr_err_i ? 1'b0 : err_q;
`endif

    // Consumer handshake; a capture below on the same edge takes precedence.
    if (prod_valid_q && prod_ready_i) begin
      prod_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (op_valid_i && op_ready_o) begin
          state_d  = S_RUN;
          mcand_d  = op_a_i;
          mplier_d = op_b_i;
        end
      end
      S_RUN: begin
        if (state_i == CTL_END) begin
          state_d      = S_RELEASE;
          prod_d       = product_i;
          prod_valid_d = 1'b1;
          done_cnt_d   = done_cnt_q + 8'd1;
        end
`ifdef MULT_SEQ_TIMEOUT_EN
        else if (wd_fire) begin
          // Abandon the job: drop the start request, no capture, no count.
          state_d = S_RELEASE;
          err_d   = 1'b1;
        end
`endif
      end
      S_RELEASE: begin
        if (state_i == CTL_IDLE) begin
          state_d = S_IDLE;
        end
`ifdef MULT_SEQ_TIMEOUT_EN
        else if (wd_fire) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Start request is registered and high exactly while in S_RUN.
    strt_d = (state_d == S_RUN);

`ifdef MULT_SEQ_TIMEOUT_EN
    // Phase counter restarts on every state change and is idle outside a job.
    if ((state_d != state_q) || (state_d == S_IDLE)) begin
      wd_d = 8'd0;
    end else begin
      wd_d = wd_q + 8'd1;
    end
`endif
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      mcand_q      <= '0;
      mplier_q     <= '0;
      strt_q       <= 1'b0;
      prod_q       <= '0;
      prod_valid_q <= 1'b0;
      done_cnt_q   <= 8'd0;
`ifdef MULT_SEQ_TIMEOUT_EN
      wd_q         <= 8'd0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      strt_q       <= strt_d;
      prod_q       <= prod_d;
      prod_valid_q <= prod_valid_d;
      done_cnt_q   <= done_cnt_d;
`ifdef MULT_SEQ_TIMEOUT_EN
      wd_q         <= wd_d;
      err_q        <= err_d;
`endif
    end
  end

  assign mcand_o      = mcand_q;
  assign mplier_o     = mplier_q;
  assign strt_cmpt_o  = strt_q;
  assign prod_o       = prod_q;
  assign prod_valid_o = prod_valid_q;
  assign done_cnt_o   = done_cnt_q;
`ifdef MULT_SEQ_TIMEOUT_EN
  assign err_o        = err_q;
`else
  assign err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_mult_seq_initiator.sv
// Directed bench for mult_seq_initiator with a stub shift-add controller.
// The stub walks IDLE->BIT0..BIT3->END->IDLE; it can be forced to a fixed
// state to exercise the watchdog (only when MULT_SEQ_TIMEOUT_EN is defined).
module tb_mult_seq_initiator;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [3:0] op_a_i, op_b_i;
  logic       op_valid_i;
  logic       op_ready_o;
  logic [3:0] mcand_o, mplier_o;
  logic       strt_cmpt_o;
  logic [2:0] state_i;
  logic [7:0] product_i;
  logic [7:0] prod_o;
  logic       prod_valid_o;
  logic       prod_ready_i;
  logic [7:0] done_cnt_o;
  logic       err_o;
  logic       clr_err_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [2:0] ctl_q;
  logic       force_en;
  logic [2:0] force_val;

  mult_seq_initiator #(.OP_W(4), .TIMEOUT(16)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .op_a_i      (op_a_i),
    .op_b_i      (op_b_i),
    .op_valid_i  (op_valid_i),
    .op_ready_o  (op_ready_o),
    .mcand_o     (mcand_o),
    .mplier_o    (mplier_o),
    .strt_cmpt_o (strt_cmpt_o),
    .state_i     (state_i),
    .product_i   (product_i),
    .prod_o      (prod_o),
    .prod_valid_o(prod_valid_o),
    .prod_ready_i(prod_ready_i),
    .done_cnt_o  (done_cnt_o),
    .err_o       (err_o),
    .clr_err_i   (clr_err_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Stub multiplier controller.
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ctl_q <= 3'd0;
    end else if (force_en) begin
      ctl_q <= 3'd0;
    end else begin
      case (ctl_q)
        3'd0:                ctl_q <= strt_cmpt_o ? 3'd1 : 3'd0;
        3'd1, 3'd2, 3'd3, 3'd4: ctl_q <= ctl_q + 3'd1;
        default:             ctl_q <= 3'd0;
      endcase
    end
  end

  assign state_i   = force_en ? force_val : ctl_q;
  assign product_i = (state_i == 3'd5) ? (8'(mcand_o) * 8'(mplier_o)) : 8'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Offer a pair, wait for the accept and the product, check result and latency.
  task automatic run_job(input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] exp_done, output int acc);
    bit         seen;
    int         lat;
    logic [7:0] exp_p;
    exp_p      = 8'(a) * 8'(b);
    op_a_i     = a;
    op_b_i     = b;
    op_valid_i = 1'b1;
    seen       = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (op_ready_o) seen = 1'b1;
      @(posedge clk_i); #1;
      if (seen) break;
    end
    acc        = cyc;
    op_valid_i = 1'b0;
    check("accept_seen", 32'(seen), 32'd1);
    seen = 1'b0;
    lat  = 0;
    for (int t = 0; t < 40; t++) begin
      @(posedge clk_i); #1;
      lat++;
      if (prod_valid_o) begin
        seen = 1'b1;
        break;
      end
    end
    check("prod_valid_seen", 32'(seen), 32'd1);
    check("latency", 32'(lat), 32'd6);
    check("prod", 32'(prod_o), 32'(exp_p));
    check("done_cnt", 32'(done_cnt_o), 32'(exp_done));
    $display("job a=%0d b=%0d prod=%02h exp=%02h done=%0d", a, b, prod_o, exp_p, done_cnt_o);
  endtask

  initial begin
    int acc;
    int prev;
    rst_i        = 1'b0;
    op_a_i       = '0;
    op_b_i       = '0;
    op_valid_i   = 1'b0;
    prod_ready_i = 1'b0;
    clr_err_i    = 1'b0;
    force_en     = 1'b0;
    force_val    = 3'd0;

    // Reset state.
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_strt", 32'(strt_cmpt_o), 32'd0);
    check("rst_prod_valid", 32'(prod_valid_o), 32'd0);
    check("rst_done", 32'(done_cnt_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_prod", 32'(prod_o), 32'd0);
    check("rst_mcand", 32'(mcand_o), 32'd0);
    check("rst_mplier", 32'(mplier_o), 32'd0);
    check("rst_op_ready", 32'(op_ready_o), 32'd1);
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    // Single job 3x5 with the consumer always ready.
    op_a_i = 4'd3; op_b_i = 4'd5; op_valid_i = 1'b1; prod_ready_i = 1'b1;
    @(posedge clk_i); #1;
    op_valid_i = 1'b0;
    check("e0_strt", 32'(strt_cmpt_o), 32'd1);
    check("e0_mcand", 32'(mcand_o), 32'd3);
    check("e0_mplier", 32'(mplier_o), 32'd5);
    check("e0_op_ready", 32'(op_ready_o), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk_i); #1;
      check("run_strt", 32'(strt_cmpt_o), 32'd1);
    end
    @(posedge clk_i); #1;
    check("e6_strt", 32'(strt_cmpt_o), 32'd0);
    check("e6_prod_valid", 32'(prod_valid_o), 32'd1);
    check("e6_prod", 32'(prod_o), 32'h0F);
    check("e6_done", 32'(done_cnt_o), 32'd1);
    @(posedge clk_i); #1;
    check("e7_prod_valid", 32'(prod_valid_o), 32'd0);
    $display("job a=3 b=5 prod=%02h exp=0f done=%0d", prod_o, done_cnt_o);
    repeat (2) @(posedge clk_i);
    #1;

    // Back-pressure: 15x15 held until the consumer takes it.
    prod_ready_i = 1'b0;
    op_a_i = 4'd15; op_b_i = 4'd15; op_valid_i = 1'b1;
    @(posedge clk_i); #1;
    op_a_i = 4'd1; op_b_i = 4'd1;
    repeat (6) @(posedge clk_i);
    #1;
    check("bp_prod", 32'(prod_o), 32'hE1);
    check("bp_prod_valid", 32'(prod_valid_o), 32'd1);
    repeat (4) @(posedge clk_i);
    #1;
    check("bp_hold_valid", 32'(prod_valid_o), 32'd1);
    check("bp_op_ready", 32'(op_ready_o), 32'd0);
    check("bp_no_accept", 32'(mcand_o), 32'd15);
    op_valid_i   = 1'b0;
    prod_ready_i = 1'b1;
    @(posedge clk_i); #1;
    check("bp_cleared", 32'(prod_valid_o), 32'd0);
    check("bp_prod_kept", 32'(prod_o), 32'hE1);
    check("bp_op_ready_after", 32'(op_ready_o), 32'd1);
    check("bp_done", 32'(done_cnt_o), 32'd2);
    $display("job a=15 b=15 prod=%02h exp=e1 done=%0d", prod_o, done_cnt_o);

    // Reset in the middle of a job, then a fresh 7x2 job.
    op_a_i = 4'd5; op_b_i = 4'd6; op_valid_i = 1'b1;
    @(posedge clk_i); #1;
    op_valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    #1;
    check("mid_rst_strt", 32'(strt_cmpt_o), 32'd0);
    check("mid_rst_prod_valid", 32'(prod_valid_o), 32'd0);
    check("mid_rst_done", 32'(done_cnt_o), 32'd0);
    #3;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    run_job(4'd7, 4'd2, 8'd1, acc);

`ifdef MULT_SEQ_TIMEOUT_EN
    // Watchdog: controller stuck at BIT2.
    force_en = 1'b1; force_val = 3'd3;
    op_a_i = 4'd2; op_b_i = 4'd3; op_valid_i = 1'b1;
    @(posedge clk_i); #1;
    op_valid_i = 1'b0;
    repeat (15) @(posedge clk_i);
    #1;
    check("wd_e15_strt", 32'(strt_cmpt_o), 32'd1);
    check("wd_e15_err", 32'(err_o), 32'd0);
    @(posedge clk_i); #1;
    check("wd_strt", 32'(strt_cmpt_o), 32'd0);
    check("wd_err", 32'(err_o), 32'd1);
    check("wd_no_prod", 32'(prod_valid_o), 32'd0);
    check("wd_done", 32'(done_cnt_o), 32'd1);
    force_val = 3'd0;
    @(posedge clk_i); #1;
    check("wd_op_ready", 32'(op_ready_o), 32'd1);
    check("wd_err_sticky", 32'(err_o), 32'd1);
    clr_err_i = 1'b1;
    @(posedge clk_i); #1;
    clr_err_i = 1'b0;
    check("wd_clr", 32'(err_o), 32'd0);
    force_en = 1'b0;
    $display("watchdog job a=2 b=3 err=%0d done=%0d", err_o, done_cnt_o);
`endif

    // Counter wrap: 256 back-to-back jobs from a clean reset.
    rst_i = 1'b0;
    #3;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    prod_ready_i = 1'b1;
    prev = 0;
    for (int j = 0; j < 256; j++) begin
      logic [7:0] jv;
      jv = 8'(j);
      run_job(jv[3:0], 4'(j * 7 + 3), 8'(j + 1), acc);
      if (j > 0) check("spacing", 32'(acc - prev), 32'd8);
      prev = acc;
    end
    check("wrap_done", 32'(done_cnt_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
